// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: an instruction queue of (pc, inst) pairs feeding one registered decoded-packet slot.
// Optional macro RV32M_DECODE_EN enables M-extension decode; when it is undefined, funct7 = 0000001 decodes as illegal.

`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef API_REGISTER_ADDR_WIDTH
`define API_REGISTER_ADDR_WIDTH 5
`endif
`ifndef DATA_ORIGIN_WIDTH
`define DATA_ORIGIN_WIDTH 2
`define DATA_ORIGIN_REGS 2'd0
`define DATA_ORIGIN_RS1_IMM 2'd1
`define DATA_ORIGIN_PC_IMM 2'd2
`define DATA_ORIGIN_IMM 2'd3
`endif
`ifndef DATA_TARGET_WIDTH
`define DATA_TARGET_WIDTH 3
`define DATA_TARGET_ALU 3'd0
`define DATA_TARGET_MEM 3'd1
`define DATA_TARGET_PC_NEXT 3'd2
`define DATA_TARGET_IMM 3'd3
`define DATA_TARGET_CSR 3'd4
`endif
`ifndef ALU_OPCODE_WIDTH
`define ALU_OPCODE_WIDTH 4
`define ALU_OPCODE_ADD 4'd0
`define ALU_OPCODE_SUB 4'd1
`define ALU_OPCODE_SLL 4'd2
`define ALU_OPCODE_SLT 4'd3
`define ALU_OPCODE_SLTU 4'd4
`define ALU_OPCODE_XOR 4'd5
`define ALU_OPCODE_SRL 4'd6
`define ALU_OPCODE_SRA 4'd7
`define ALU_OPCODE_OR 4'd8
`define ALU_OPCODE_AND 4'd9
`endif
`ifndef LSU_OPCODE_WIDTH
`define LSU_OPCODE_WIDTH 4
`define LSU_OPCODE_NONE 4'd0
`define LSU_OPCODE_LB 4'd1
`define LSU_OPCODE_LH 4'd2
`define LSU_OPCODE_LW 4'd3
`define LSU_OPCODE_LBU 4'd4
`define LSU_OPCODE_LHU 4'd5
`define LSU_OPCODE_SB 4'd6
`define LSU_OPCODE_SH 4'd7
`define LSU_OPCODE_SW 4'd8
`endif
`ifndef BR_OPCODE_WIDTH
`define BR_OPCODE_WIDTH 3
`endif
`ifndef CSR_OPCODE_WIDTH
`define CSR_OPCODE_WIDTH 3
`endif
`ifndef CSR_WIDTH
`define CSR_WIDTH 12
`endif

module rv32_decode_stage #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic                                inst_valid_i,
  output logic                                inst_ready_o,
  input  logic [`API_DATA_WIDTH-1:0]          inst_i,
  input  logic [PC_WIDTH-1:0]                 pc_i,
  output logic                                dec_valid_o,
  input  logic                                dec_ready_i,
  output logic [PC_WIDTH-1:0]                 pc_o,
  output logic [`DATA_ORIGIN_WIDTH-1:0]       data_origin_o,
  output logic [`DATA_TARGET_WIDTH-1:0]       data_target_o,
  output logic [`API_DATA_WIDTH-1:0]          imm_o,
  output logic [`API_REGISTER_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [`API_REGISTER_ADDR_WIDTH-1:0] rs2_addr_o,
  output logic [`API_REGISTER_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [`ALU_OPCODE_WIDTH-1:0]        alu_opcode_o,
  output logic [`LSU_OPCODE_WIDTH-1:0]        lsu_opcode_o,
  output logic [`BR_OPCODE_WIDTH-1:0]         br_opcode_o,
  output logic                                is_branch_o,
  output logic                                is_condition_o,
  output logic [`CSR_OPCODE_WIDTH-1:0]        csr_opcode_o,
  output logic [`CSR_WIDTH-1:0]               csr_addr_o,
  output logic                                csr_we_o,
  output logic                                csr_re_o,
  output logic [2:0]                          md_opcode_o,
  output logic                                is_md_o,
  output logic                                illegal_o,
  output logic                                mem_w_o,
  output logic                                reg_w_o,
  output logic [$clog2(DEPTH):0]              occupancy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0]                 pc;
    logic [`DATA_ORIGIN_WIDTH-1:0]       origin;
    logic [`DATA_TARGET_WIDTH-1:0]       target;
    logic [`API_DATA_WIDTH-1:0]          imm;
    logic [`API_REGISTER_ADDR_WIDTH-1:0] rs1;
    logic [`API_REGISTER_ADDR_WIDTH-1:0] rs2;
    logic [`API_REGISTER_ADDR_WIDTH-1:0] rd;
    logic [`ALU_OPCODE_WIDTH-1:0]        alu;
    logic [`LSU_OPCODE_WIDTH-1:0]        lsu;
    logic [`BR_OPCODE_WIDTH-1:0]         br;
    logic                                isBranch;
    logic                                isCond;
    logic [`CSR_OPCODE_WIDTH-1:0]        csrOp;
    logic [`CSR_WIDTH-1:0]               csrAddr;
    logic                                csrWe;
    logic                                csrRe;
    logic [2:0]                          mdOp;
    logic                                isMd;
    logic                                illegal;
    logic                                memW;
    logic                                regW;
  } pkt_t;

  logic [AW:0]                 wrPtr_q, rdPtr_q;
  logic [`API_DATA_WIDTH-1:0]  instMem_q [DEPTH];
  logic [PC_WIDTH-1:0]         pcMem_q [DEPTH];
  logic                        decValid_q;
  pkt_t                        pkt_q, pkt_d;
  logic                        push, pop, empty;
  logic [`API_DATA_WIDTH-1:0]  headInst;

  assign occupancy_o  = wrPtr_q - rdPtr_q;
  assign empty        = (occupancy_o == '0);
  assign inst_ready_o = (occupancy_o != FULL_COUNT);
  assign push         = inst_valid_i && inst_ready_o && !flush_i;
  assign pop          = !empty && (!decValid_q || dec_ready_i) && !flush_i;
  assign headInst     = instMem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instMem_q[wrPtr_q[AW-1:0]] <= inst_i;
      pcMem_q[wrPtr_q[AW-1:0]]   <= pc_i;
    end
  end

  function automatic logic [`ALU_OPCODE_WIDTH-1:0] aluOp(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    aluOp = alt ? `ALU_OPCODE_SUB : `ALU_OPCODE_ADD;
      3'd1:    aluOp = `ALU_OPCODE_SLL;
      3'd2:    aluOp = `ALU_OPCODE_SLT;
      3'd3:    aluOp = `ALU_OPCODE_SLTU;
      3'd4:    aluOp = `ALU_OPCODE_XOR;
      3'd5:    aluOp = alt ? `ALU_OPCODE_SRA : `ALU_OPCODE_SRL;
      3'd6:    aluOp = `ALU_OPCODE_OR;
      default: aluOp = `ALU_OPCODE_AND;
    endcase
  endfunction

  // Decode of the queue head; any illegal encoding collapses to a zero packet with only illegal set.
  always_comb begin
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;
    logic       illegal;
    opc = headInst[6:0];
    rd  = headInst[11:7];
    f3  = headInst[14:12];
    rs1 = headInst[19:15];
    rs2 = headInst[24:20];
    f7  = headInst[31:25];
    illegal = 1'b0;
    pkt_d = '0;
    pkt_d.alu = `ALU_OPCODE_ADD;
    case (opc)
      7'b0110011: begin
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))) begin
          pkt_d.alu = aluOp(f3, f7[5]);
          pkt_d.rs1 = rs1; pkt_d.rs2 = rs2; pkt_d.rd = rd; pkt_d.regW = 1'b1;
        end
`ifdef RV32M_DECODE_EN
        else if (f7 == 7'b0000001) begin
          pkt_d.isMd = 1'b1; pkt_d.mdOp = f3; pkt_d.target = `DATA_TARGET_ALU;
          pkt_d.rs1 = rs1; pkt_d.rs2 = rs2; pkt_d.rd = rd; pkt_d.regW = 1'b1;
        end
`endif
        else illegal = 1'b1;
      end
      7'b0010011: begin
        if ((f3 == 3'd1 && f7 != 7'b0000000) ||
            (f3 == 3'd5 && f7 != 7'b0000000 && f7 != 7'b0100000)) illegal = 1'b1;
        pkt_d.alu    = aluOp(f3, (f3 == 3'd5) && f7[5]);
        pkt_d.imm    = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, rs2} : {{20{headInst[31]}}, headInst[31:20]};
        pkt_d.origin = `DATA_ORIGIN_RS1_IMM;
        pkt_d.rs1 = rs1; pkt_d.rd = rd; pkt_d.regW = 1'b1;
      end
      7'b0000011: begin
        case (f3)
          3'd0:    pkt_d.lsu = `LSU_OPCODE_LB;
          3'd1:    pkt_d.lsu = `LSU_OPCODE_LH;
          3'd2:    pkt_d.lsu = `LSU_OPCODE_LW;
          3'd4:    pkt_d.lsu = `LSU_OPCODE_LBU;
          3'd5:    pkt_d.lsu = `LSU_OPCODE_LHU;
          default: illegal = 1'b1;
        endcase
        pkt_d.imm    = {{20{headInst[31]}}, headInst[31:20]};
        pkt_d.origin = `DATA_ORIGIN_RS1_IMM;
        pkt_d.target = `DATA_TARGET_MEM;
        pkt_d.rs1 = rs1; pkt_d.rd = rd; pkt_d.regW = 1'b1;
      end
      7'b0100011: begin
        case (f3)
          3'd0:    pkt_d.lsu = `LSU_OPCODE_SB;
          3'd1:    pkt_d.lsu = `LSU_OPCODE_SH;
          3'd2:    pkt_d.lsu = `LSU_OPCODE_SW;
          default: illegal = 1'b1;
        endcase
        pkt_d.imm    = {{20{headInst[31]}}, headInst[31:25], headInst[11:7]};
        pkt_d.origin = `DATA_ORIGIN_RS1_IMM;
        pkt_d.target = `DATA_TARGET_MEM;
        pkt_d.rs1 = rs1; pkt_d.rs2 = rs2; pkt_d.memW = 1'b1;
      end
      7'b1100011: begin
        if (f3 == 3'd2 || f3 == 3'd3) illegal = 1'b1;
        pkt_d.imm = {{19{headInst[31]}}, headInst[31], headInst[7], headInst[30:25], headInst[11:8], 1'b0};
        pkt_d.br  = f3;
        pkt_d.isBranch = 1'b1; pkt_d.isCond = 1'b1;
        pkt_d.rs1 = rs1; pkt_d.rs2 = rs2;
      end
      7'b1101111: begin
        pkt_d.imm = {{11{headInst[31]}}, headInst[31], headInst[19:12], headInst[20], headInst[30:21], 1'b0};
        pkt_d.origin = `DATA_ORIGIN_PC_IMM;
        pkt_d.target = `DATA_TARGET_PC_NEXT;
        pkt_d.isBranch = 1'b1; pkt_d.rd = rd; pkt_d.regW = 1'b1;
      end
      7'b1100111: begin
        if (f3 != 3'd0) illegal = 1'b1;
        pkt_d.imm    = {{20{headInst[31]}}, headInst[31:20]};
        pkt_d.origin = `DATA_ORIGIN_RS1_IMM;
        pkt_d.target = `DATA_TARGET_PC_NEXT;
        pkt_d.isBranch = 1'b1; pkt_d.rs1 = rs1; pkt_d.rd = rd; pkt_d.regW = 1'b1;
      end
      7'b0110111: begin
        pkt_d.imm = {headInst[31:12], 12'b0};
        pkt_d.origin = `DATA_ORIGIN_IMM; pkt_d.target = `DATA_TARGET_IMM;
        pkt_d.rd = rd; pkt_d.regW = 1'b1;
      end
      7'b0010111: begin
        pkt_d.imm = {headInst[31:12], 12'b0};
        pkt_d.origin = `DATA_ORIGIN_PC_IMM; pkt_d.target = `DATA_TARGET_ALU;
        pkt_d.rd = rd; pkt_d.regW = 1'b1;
      end
      7'b0001111: ;
      7'b1110011: begin
        if (f3 == 3'd0) begin
          // Only ECALL and EBREAK are accepted among the privileged encodings.
          if (!((headInst[31:20] == 12'h000 || headInst[31:20] == 12'h001) && rs1 == 5'd0 && rd == 5'd0))
            illegal = 1'b1;
        end else if (f3 == 3'd4) begin
          illegal = 1'b1;
        end else begin
          pkt_d.csrOp   = f3;
          pkt_d.csrAddr = headInst[31:20];
          pkt_d.target  = `DATA_TARGET_CSR;
          pkt_d.rd = rd; pkt_d.regW = 1'b1;
          if (f3[2]) begin
            pkt_d.imm = {27'b0, rs1}; pkt_d.origin = `DATA_ORIGIN_IMM;
          end else begin
            pkt_d.rs1 = rs1; pkt_d.origin = `DATA_ORIGIN_REGS;
          end
          if (f3[1:0] == 2'b01) begin
            pkt_d.csrWe = 1'b1; pkt_d.csrRe = (rd != 5'd0);
          end else begin
            pkt_d.csrRe = 1'b1; pkt_d.csrWe = (rs1 != 5'd0);
          end
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      pkt_d = '0;
      pkt_d.alu = `ALU_OPCODE_ADD;
      pkt_d.illegal = 1'b1;
    end
    pkt_d.pc = pcMem_q[rdPtr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decValid_q <= 1'b0;
      pkt_q      <= '0;
      pkt_q.alu  <= `ALU_OPCODE_ADD;
    end else if (flush_i) begin
      decValid_q <= 1'b0;
    end else if (pop) begin
      decValid_q <= 1'b1;
      pkt_q      <= pkt_d;
    end else if (dec_ready_i) begin
      decValid_q <= 1'b0;
    end
  end

  assign dec_valid_o    = decValid_q;
  assign pc_o           = pkt_q.pc;
  assign data_origin_o  = pkt_q.origin;
  assign data_target_o  = pkt_q.target;
  assign imm_o          = pkt_q.imm;
  assign rs1_addr_o     = pkt_q.rs1;
  assign rs2_addr_o     = pkt_q.rs2;
  assign rd_addr_o      = pkt_q.rd;
  assign alu_opcode_o   = pkt_q.alu;
  assign lsu_opcode_o   = pkt_q.lsu;
  assign br_opcode_o    = pkt_q.br;
  assign is_branch_o    = pkt_q.isBranch;
  assign is_condition_o = pkt_q.isCond;
  assign csr_opcode_o   = pkt_q.csrOp;
  assign csr_addr_o     = pkt_q.csrAddr;
  assign csr_we_o       = pkt_q.csrWe;
  assign csr_re_o       = pkt_q.csrRe;
  assign md_opcode_o    = pkt_q.mdOp;
  assign is_md_o        = pkt_q.isMd;
  assign illegal_o      = pkt_q.illegal;
  assign mem_w_o        = pkt_q.memW;
  assign reg_w_o        = pkt_q.regW;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Testbench for rv32_decode_stage: constant decode table driven through a scoreboard,
// plus hand-written backpressure, flush and mid-stream reset sequences.

`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef API_REGISTER_ADDR_WIDTH
`define API_REGISTER_ADDR_WIDTH 5
`endif
`ifndef DATA_ORIGIN_WIDTH
`define DATA_ORIGIN_WIDTH 2
`define DATA_ORIGIN_REGS 2'd0
`define DATA_ORIGIN_RS1_IMM 2'd1
`define DATA_ORIGIN_PC_IMM 2'd2
`define DATA_ORIGIN_IMM 2'd3
`endif
`ifndef DATA_TARGET_WIDTH
`define DATA_TARGET_WIDTH 3
`define DATA_TARGET_ALU 3'd0
`define DATA_TARGET_MEM 3'd1
`define DATA_TARGET_PC_NEXT 3'd2
`define DATA_TARGET_IMM 3'd3
`define DATA_TARGET_CSR 3'd4
`endif
`ifndef ALU_OPCODE_WIDTH
`define ALU_OPCODE_WIDTH 4
`define ALU_OPCODE_ADD 4'd0
`define ALU_OPCODE_SUB 4'd1
`define ALU_OPCODE_SLL 4'd2
`define ALU_OPCODE_SLT 4'd3
`define ALU_OPCODE_SLTU 4'd4
`define ALU_OPCODE_XOR 4'd5
`define ALU_OPCODE_SRL 4'd6
`define ALU_OPCODE_SRA 4'd7
`define ALU_OPCODE_OR 4'd8
`define ALU_OPCODE_AND 4'd9
`endif
`ifndef LSU_OPCODE_WIDTH
`define LSU_OPCODE_WIDTH 4
`define LSU_OPCODE_NONE 4'd0
`define LSU_OPCODE_LB 4'd1
`define LSU_OPCODE_LH 4'd2
`define LSU_OPCODE_LW 4'd3
`define LSU_OPCODE_LBU 4'd4
`define LSU_OPCODE_LHU 4'd5
`define LSU_OPCODE_SB 4'd6
`define LSU_OPCODE_SH 4'd7
`define LSU_OPCODE_SW 4'd8
`endif
`ifndef BR_OPCODE_WIDTH
`define BR_OPCODE_WIDTH 3
`endif
`ifndef CSR_OPCODE_WIDTH
`define CSR_OPCODE_WIDTH 3
`endif
`ifndef CSR_WIDTH
`define CSR_WIDTH 12
`endif

module tb_rv32_decode_stage;
  localparam int DEPTH = 4;
  localparam int NV    = 20;

  logic clk = 1'b0;
  logic rst, flush_i, inst_valid_i, inst_ready_o, dec_valid_o, dec_ready_i;
  logic [31:0] inst_i, pc_i, pc_o, imm_o;
  logic [1:0]  data_origin_o;
  logic [2:0]  data_target_o, br_opcode_o, csr_opcode_o, md_opcode_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [3:0]  alu_opcode_o, lsu_opcode_o;
  logic [11:0] csr_addr_o;
  logic        is_branch_o, is_condition_o, csr_we_o, csr_re_o, is_md_o, illegal_o, mem_w_o, reg_w_o;
  logic [2:0]  occupancy_o;

  rv32_decode_stage #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o), .inst_i(inst_i), .pc_i(pc_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .pc_o(pc_o),
    .data_origin_o(data_origin_o), .data_target_o(data_target_o), .imm_o(imm_o),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
    .alu_opcode_o(alu_opcode_o), .lsu_opcode_o(lsu_opcode_o), .br_opcode_o(br_opcode_o),
    .is_branch_o(is_branch_o), .is_condition_o(is_condition_o),
    .csr_opcode_o(csr_opcode_o), .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o), .csr_re_o(csr_re_o),
    .md_opcode_o(md_opcode_o), .is_md_o(is_md_o), .illegal_o(illegal_o),
    .mem_w_o(mem_w_o), .reg_w_o(reg_w_o), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [3:0]  lsu;
    logic [2:0]  br;
    logic        isBr;
    logic        isCond;
    logic [2:0]  csrOp;
    logic [11:0] csrAddr;
    logic        csrWe;
    logic        csrRe;
    logic        isMd;
    logic [2:0]  mdOp;
    logic        illegal;
    logic        memW;
    logic        regW;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  origin;
    logic [2:0]  target;
  } vec_t;

  typedef struct packed {
    vec_t        v;
    logic [31:0] pc;
  } sb_t;

  vec_t        vecs [NV];
  vec_t        idle;
  sb_t         sbQ [$];
  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;
  logic [31:0] pcNext;

  function automatic vec_t mkVec(
    input logic [31:0] inst, input logic [31:0] imm, input logic [3:0] alu, input logic [3:0] lsu,
    input logic [2:0] br, input logic isBr, input logic isCond, input logic [2:0] csrOp,
    input logic [11:0] csrAddr, input logic csrWe, input logic csrRe, input logic isMd,
    input logic [2:0] mdOp, input logic illegal, input logic memW, input logic regW,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [1:0] origin, input logic [2:0] target);
    vec_t v;
    v.inst = inst; v.imm = imm; v.alu = alu; v.lsu = lsu; v.br = br; v.isBr = isBr; v.isCond = isCond;
    v.csrOp = csrOp; v.csrAddr = csrAddr; v.csrWe = csrWe; v.csrRe = csrRe; v.isMd = isMd; v.mdOp = mdOp;
    v.illegal = illegal; v.memW = memW; v.regW = regW; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.origin = origin; v.target = target;
    return v;
  endfunction

  function automatic vec_t mkIll(input logic [31:0] inst);
    vec_t v;
    v = '0;
    v.inst = inst;
    v.illegal = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus: compare any packet consumed this cycle, record any accepted push.
  task automatic applyStimulus(input logic valid, input vec_t v, input logic rdy, input logic fl);
    sb_t  e;
    vec_t a;
    inst_valid_i = valid;
    inst_i       = v.inst;
    pc_i         = pcNext;
    dec_ready_i  = rdy;
    flush_i      = fl;
    if (!fl) begin
      if (dec_valid_o && dec_ready_i) begin
        consumed++;
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_packet actual=%h required=none", imm_o);
        end else begin
          e = sbQ.pop_front();
          a = mkVec(e.v.inst, imm_o, alu_opcode_o, lsu_opcode_o, br_opcode_o, is_branch_o, is_condition_o,
                    csr_opcode_o, csr_addr_o, csr_we_o, csr_re_o, is_md_o, md_opcode_o, illegal_o,
                    mem_w_o, reg_w_o, rd_addr_o, rs1_addr_o, rs2_addr_o, data_origin_o, data_target_o);
          checkOutput($sformatf("pkt_%h", e.v.inst), {{(128-$bits(vec_t)){1'b0}}, a},
                      {{(128-$bits(vec_t)){1'b0}}, e.v});
          checkOutput($sformatf("pc_%h", e.v.inst), {96'b0, pc_o}, {96'b0, e.pc});
        end
      end
      if (inst_valid_i && inst_ready_o) begin
        e.v  = v;
        e.pc = pcNext;
        sbQ.push_back(e);
        pcNext = pcNext + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    if (fl) sbQ.delete();
  endtask

  task automatic drain(input int maxCycles);
    for (int c = 0; c < maxCycles && sbQ.size() != 0; c++) applyStimulus(1'b0, idle, 1'b1, 1'b0);
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0", sbQ.size());
      sbQ.delete();
    end
  endtask

  initial begin
    int   c0, idx;
    logic rv, rr, acc;

    vecs[0]  = mkVec(32'h00A28293, 32'h0000000A, 4'd0, 4'd0, 3'd0, 0, 0, 3'd0, 12'h000, 0, 0, 0, 3'd0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 2'd1, 3'd0);
    vecs[1]  = mkVec(32'hFE000EE3, 32'hFFFFFFFC, 4'd0, 4'd0, 3'd0, 1, 1, 3'd0, 12'h000, 0, 0, 0, 3'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 2'd0, 3'd0);
    vecs[2]  = mkVec(32'h30002573, 32'h00000000, 4'd0, 4'd0, 3'd0, 0, 0, 3'd2, 12'h300, 0, 1, 0, 3'd0, 0, 0, 1, 5'd10, 5'd0, 5'd0, 2'd0, 3'd4);
    vecs[3]  = mkIll(32'h0000707F);
`ifdef RV32M_DECODE_EN
    vecs[4]  = mkVec(32'h02B50533, 32'h00000000, 4'd0, 4'd0, 3'd0, 0, 0, 3'd0, 12'h000, 0, 0, 1, 3'd0, 0, 0, 1, 5'd10, 5'd10, 5'd11, 2'd0, 3'd0);
`else
    vecs[4]  = mkIll(32'h02B50533);
`endif
    vecs[5]  = mkVec(32'h402081B3, 32'h00000000, 4'd1, 4'd0, 3'd0, 0, 0, 3'd0, 12'h000, 0, 0, 0, 3'd0, 0, 0, 1, 5'd3, 5'd1, 5'd2, 2'd0, 3'd0);
    vecs[6]  = mkIll(32'h402091B3);
    vecs[7]  = mkVec(32'h40325213, 32'h00000003, 4'd7, 4'd0, 3'd0, 0, 0, 3'd0, 12'h000, 0, 0, 0, 3'd0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 2'd1, 3'd0);
    vecs[8]  = mkVec(32'hFF812303, 32'hFFFFFFF8, 4'd0, 4'd3, 3'd0, 0, 0, 3'd0, 12'h000, 0, 0, 0, 3'd0, 0, 0, 1, 5'd6, 5'd2, 5'd0, 2'd1, 3'd1);
    vecs[9]  = mkIll(32'h00013303);
    vecs[10] = mkVec(32'h00712623, 32'h0000000C, 4'd0, 4'd8, 3'd0, 0, 0, 3'd0, 12'h000, 0, 0, 0, 3'd0, 0, 1, 0, 5'd0, 5'd2, 5'd7, 2'd1, 3'd1);
    vecs[11] = mkVec(32'h3052D073, 32'h00000005, 4'd0, 4'd0, 3'd0, 0, 0, 3'd5, 12'h305, 1, 0, 0, 3'd0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 2'd3, 3'd4);
    vecs[12] = mkVec(32'h340130F3, 32'h00000000, 4'd0, 4'd0, 3'd0, 0, 0, 3'd3, 12'h340, 1, 1, 0, 3'd0, 0, 0, 1, 5'd1, 5'd2, 5'd0, 2'd0, 3'd4);
    vecs[13] = mkVec(32'h008000EF, 32'h00000008, 4'd0, 4'd0, 3'd0, 1, 0, 3'd0, 12'h000, 0, 0, 0, 3'd0, 0, 0, 1, 5'd1, 5'd0, 5'd0, 2'd2, 3'd2);
    vecs[14] = mkIll(32'h00009067);
    vecs[15] = mkVec(32'h123452B7, 32'h12345000, 4'd0, 4'd0, 3'd0, 0, 0, 3'd0, 12'h000, 0, 0, 0, 3'd0, 0, 0, 1, 5'd5, 5'd0, 5'd0, 2'd3, 3'd3);
    vecs[16] = mkVec(32'h0FF0000F, 32'h00000000, 4'd0, 4'd0, 3'd0, 0, 0, 3'd0, 12'h000, 0, 0, 0, 3'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 2'd0, 3'd0);
    vecs[17] = mkVec(32'h00000073, 32'h00000000, 4'd0, 4'd0, 3'd0, 0, 0, 3'd0, 12'h000, 0, 0, 0, 3'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 2'd0, 3'd0);
    vecs[18] = mkIll(32'h30004073);
    vecs[19] = mkVec(32'h00209863, 32'h00000010, 4'd0, 4'd0, 3'd1, 1, 1, 3'd0, 12'h000, 0, 0, 0, 3'd0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 2'd0, 3'd0);
    idle = '0;

    pcNext = 32'h0000_1000;
    rst = 1'b1; flush_i = 1'b0; inst_valid_i = 1'b0; dec_ready_i = 1'b0; inst_i = '0; pc_i = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_occupancy", {125'b0, occupancy_o}, 128'd0);
    checkOutput("rst_dec_valid", {127'b0, dec_valid_o}, 128'd0);
    checkOutput("rst_inst_ready", {127'b0, inst_ready_o}, 128'd1);
    checkOutput("rst_alu", {124'b0, alu_opcode_o}, {124'b0, `ALU_OPCODE_ADD});
    checkOutput("rst_fields", {96'b0, imm_o}, {96'b0, 32'd0});
    checkOutput("rst_flags", {124'b0, reg_w_o, mem_w_o, illegal_o, csr_we_o}, 128'd0);

    $display("[TB] single addi latency");
    applyStimulus(1'b1, vecs[0], 1'b1, 1'b0);
    applyStimulus(1'b0, idle, 1'b1, 1'b0);
    checkOutput("latency_valid", {127'b0, dec_valid_o}, 128'd1);
    drain(10);

    $display("[TB] table stream at full rate");
    c0 = consumed;
    for (int i = 0; i < NV; i++) applyStimulus(1'b1, vecs[i], 1'b1, 1'b0);
    applyStimulus(1'b0, idle, 1'b1, 1'b0);
    applyStimulus(1'b0, idle, 1'b1, 1'b0);
    checkOutput("throughput", 128'(consumed - c0), 128'(NV));
    drain(10);
    checkOutput("stream_occupancy", {125'b0, occupancy_o}, 128'd0);

    $display("[TB] table stream with random handshakes");
    idx = 0;
    for (int c = 0; c < 400 && idx < NV; c++) begin
      rv  = 1'($urandom_range(0, 1));
      rr  = 1'($urandom_range(0, 1));
      acc = rv && inst_ready_o;
      applyStimulus(rv, vecs[idx], rr, 1'b0);
      if (acc) idx++;
    end
    checkOutput("random_all_pushed", 128'(idx), 128'(NV));
    drain(20);

    $display("[TB] backpressure fill and drain");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, vecs[i], 1'b0, 1'b0);
    checkOutput("full_ready", {127'b0, inst_ready_o}, 128'd0);
    checkOutput("full_occupancy", {125'b0, occupancy_o}, 128'd4);
    applyStimulus(1'b1, vecs[5], 1'b0, 1'b0);
    checkOutput("full_no_push", {125'b0, occupancy_o}, 128'd4);
    c0 = consumed;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, idle, 1'b1, 1'b0);
    checkOutput("drain_rate", 128'(consumed - c0), 128'd5);
    checkOutput("drain_empty", 128'(sbQ.size()), 128'd0);
    checkOutput("drain_valid_low", {127'b0, dec_valid_o}, 128'd0);

    $display("[TB] flush with full queue and push");
    for (int i = 6; i < 11; i++) applyStimulus(1'b1, vecs[i], 1'b0, 1'b0);
    applyStimulus(1'b1, vecs[11], 1'b0, 1'b1);
    checkOutput("flush_full_occ", {125'b0, occupancy_o}, 128'd0);
    checkOutput("flush_full_valid", {127'b0, dec_valid_o}, 128'd0);
    checkOutput("flush_full_ready", {127'b0, inst_ready_o}, 128'd1);

    $display("[TB] flush with partial queue and push");
    applyStimulus(1'b1, vecs[12], 1'b0, 1'b0);
    applyStimulus(1'b1, vecs[13], 1'b0, 1'b0);
    applyStimulus(1'b1, vecs[14], 1'b1, 1'b1);
    checkOutput("flush_part_occ", {125'b0, occupancy_o}, 128'd0);
    checkOutput("flush_part_valid", {127'b0, dec_valid_o}, 128'd0);
    applyStimulus(1'b0, idle, 1'b1, 1'b0);
    checkOutput("flush_push_dropped", {127'b0, dec_valid_o}, 128'd0);
    applyStimulus(1'b1, vecs[4], 1'b1, 1'b0);
    drain(10);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, vecs[i], 1'b0, 1'b0);
    checkOutput("pre_rst_occ", {125'b0, occupancy_o}, 128'd3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_occ", {125'b0, occupancy_o}, 128'd0);
    checkOutput("async_rst_valid", {127'b0, dec_valid_o}, 128'd0);
    checkOutput("async_rst_ready", {127'b0, inst_ready_o}, 128'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbQ.delete();
    applyStimulus(1'b1, vecs[19], 1'b1, 1'b0);
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/rv32_decode_stage.md
Name: rv32_decode_stage

Overview:
- Buffered, handshaked successor to the combinational RV32IM decoder/control unit.
- Sits between fetch and execute. A parametrised instruction queue of (pc, instruction) pairs feeds the decode logic, which writes one registered decoded-packet slot.
- Adds illegal-instruction detection, flush, backpressure, a sign-correct branch immediate, and correct CSR read/write enables.
- Every output is driven to a defined value, never high-impedance.

Parameters:
- DEPTH, 4: instruction-queue entries. Must be a power of two, at least 2.
- PC_WIDTH, 32: width of pc_i and pc_o.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush_i  in  1  discard all queued and decoded instructions
- inst_valid_i  in  1  fetch offers an instruction
- inst_ready_o  out  1  queue can accept (not full)
- inst_i  in  `API_DATA_WIDTH  instruction word
- pc_i  in  PC_WIDTH  instruction address
- dec_valid_o  out  1  decoded packet valid
- dec_ready_i  in  1  execute accepts packet
- pc_o  out  PC_WIDTH  pc of packet
- data_origin_o  out  `DATA_ORIGIN_WIDTH  operand source
- data_target_o  out  `DATA_TARGET_WIDTH  writeback source
- imm_o  out  `API_DATA_WIDTH  sign-extended immediate
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  `API_REGISTER_ADDR_WIDTH each  register addresses
- alu_opcode_o  out  `ALU_OPCODE_WIDTH  ALU operation
- lsu_opcode_o  out  `LSU_OPCODE_WIDTH  load/store operation
- br_opcode_o  out  `BR_OPCODE_WIDTH  branch condition
- is_branch_o, is_condition_o  out  1 each  branch / conditional-branch flags
- csr_opcode_o  out  `CSR_OPCODE_WIDTH  CSR operation
- csr_addr_o  out  `CSR_WIDTH  CSR address
- csr_we_o, csr_re_o  out  1 each  CSR write / read enable
- md_opcode_o  out  3  M-extension funct3 (see Optional Feature)
- is_md_o  out  1  packet is a mul/div operation
- illegal_o  out  1  packet is an illegal instruction
- mem_w_o, reg_w_o  out  1 each  memory write / register write
- occupancy_o  out  $clog2(DEPTH)+1  queued entry count

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Queue pointers and occupancy_o are 0. inst_ready_o is 1 during and after reset.
  - dec_valid_o is 0. Every packet field is 0, and alu_opcode_o = `ALU_OPCODE_ADD.
- Queue: circular buffer with read and write pointers, each with one extra wrap bit.
  - Push when inst_valid_i && inst_ready_o. inst_ready_o = (occupancy_o != DEPTH).
  - Pop when the queue is not empty and the slot is free, i.e. !dec_valid_o || dec_ready_i.
  - Push and pop in the same cycle are both allowed when full: occupancy is unchanged, but ready is still 0 that cycle. No bypass into a full queue.
  - Pointers wrap modulo DEPTH.
- Slot: on pop, the slot registers the decode of the queue head and dec_valid_o goes to 1.
  - If dec_ready_i && dec_valid_o and there is no pop, dec_valid_o goes to 0.
  - Packet fields hold while dec_valid_o && !dec_ready_i.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N+1 when the pipeline is empty.
- Throughput: one instruction per cycle under continuous ready.
- Flush: synchronous and highest priority. In that cycle the queue is emptied, dec_valid_o is cleared, and a simultaneous push is dropped.
- Decode, RV32I:
  - R_ALU: funct7 must be 0000000, or 0100000 only with funct3 000 (SUB) or 101 (SRA).
  - I_ALU: funct7 is ignored except for shifts. SLLI requires 0000000; SRLI/SRAI use 0000000/0100000.
  - LOAD: funct3 3, 6 and 7 are illegal.
  - STORE: funct3 above 2 is illegal. data_target_o = `DATA_TARGET_MEM.
  - BRANCH: funct3 2 and 3 are illegal. imm_o is the sign-extended {imm[12:1], 0}.
  - JAL/JALR: as before. JALR requires funct3 = 0.
  - LUI/AUIPC: as before.
  - FENCE: legal, treated as a no-op with all write enables 0.
- Decode, SYSTEM (CSR):
  - CSRRW/CSRRWI: csr_we_o = 1; csr_re_o = (rd != 0).
  - CSRRS/CSRRC/CSRRSI/CSRRCI: csr_re_o = 1; csr_we_o = (rs1/uimm != 0).
  - CSRRC maps to its own opcode, not CSRRS.
  - Immediate forms: imm_o = the zero-extended 5-bit uimm held in the rs1 field.
  - funct3 4 is illegal.
  - ECALL/EBREAK: legal, no writes.
- Decode, unknown opcode: illegal.
- Illegal packet: illegal_o = 1 and reg_w_o = mem_w_o = csr_we_o = is_branch_o = 0. Other fields are 0.
- rd = x0: reg_w_o is still set. The register file ignores writes to x0.

Optional Feature:
- Macro: RV32M_DECODE_EN.
- Defined: R_ALU with funct7 = 0000001 decodes to is_md_o = 1, md_opcode_o = funct3, reg_w_o = 1, data_target_o = `DATA_TARGET_ALU.
- Undefined: that encoding is illegal; is_md_o = 0 and md_opcode_o = 0 always.

Test Plan:
- Reset mid-stream with 3 entries queued → occupancy_o = 0, dec_valid_o = 0, inst_ready_o = 1 immediately.
- Push 0x00A28293 (addi x5,x5,10), dec_ready_i = 1 → one cycle later: dec_valid_o = 1, imm_o = 0x0000000A, alu ADD, reg_w_o = 1, rd = 5, illegal_o = 0.
- dec_ready_i = 0, push 5 instructions with DEPTH = 4 → after 4 queued plus 1 in the slot, inst_ready_o = 0 and occupancy_o = 4. Release → in-order drain, one per cycle.
- Push 0xFE000EE3 (beq x0,x0,-4) → imm_o = 0xFFFFFFFC, is_condition_o = 1, br BEQ.
- Push 0x30002573 (csrr a0,mstatus) → csr_re_o = 1, csr_we_o = 0, csr_addr_o = 0x300. Push 0x0000707F → illegal_o = 1, reg_w_o = 0.
- Flush asserted with a simultaneous push and a full queue → next cycle occupancy_o = 0 and dec_valid_o = 0. Push 0x02B50533 (mul) → is_md_o = 1 with RV32M_DECODE_EN, illegal_o = 1 without it.
